// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame packer.
package adc_frame_pkg;

  localparam int FRAME_CNT_W = 16;
  localparam int DATA_W      = 14;
  localparam int A_LSB       = 0;
  localparam int A_OVR       = 15;
  localparam int B_LSB       = 16;
  localparam int B_OVR       = 31;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    DRAIN
  } state_t;

  function automatic logic [31:0] pack_word(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic              ova,
    input logic              ovb
  );
    logic [31:0] w;
    w = '0;
    w[A_LSB +: DATA_W] = a;
    w[A_OVR]           = ova;
    w[B_LSB +: DATA_W] = b;
    w[B_OVR]           = ovb;
    return w;
  endfunction

endpackage

// File: rtl/adc_frame_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module adc_frame_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head is muxed to zero when empty so the port reads 0 after reset.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/adc_frame_packer.sv
// Arm/trigger frame capture of AD9648 sample pairs into a 32-bit stream.
// Optional 2^DECIM_LOG2 averaging is enabled by ADC_FRAME_DECIM_EN.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int BIT_WIDTH  = 14,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16,
  parameter int DECIM_LOG2 = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   enable_in,
  input  logic                   trigger_in,
  input  logic                   sample_valid_in,
  input  logic [BIT_WIDTH-1:0]   data_a_in,
  input  logic [BIT_WIDTH-1:0]   data_b_in,
  input  logic                   overrange_a_in,
  input  logic                   overrange_b_in,
  output logic [31:0]            m_data_out,
  output logic                   m_valid_out,
  input  logic                   m_ready_in,
  output logic                   m_last_out,
  output logic                   busy_out,
  output logic                   overflow_out,
  output logic [FRAME_CNT_W-1:0] frame_count_out
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

  if (BIT_WIDTH > DATA_W || FRAME_LEN < 2 || FIFO_DEPTH < 4 ||
      DECIM_LOG2 < 1) begin : g_bad_param
    $error("adc_frame_packer: illegal parameter set");
  end

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  word_cnt;
  logic [OCC_W-1:0]  occ;
  logic              full;
  logic              empty;
  logic              word_vld;
  logic              is_last;
  logic              room;
  logic              push;
  logic [DATA_W-1:0] a_w;
  logic [DATA_W-1:0] b_w;
  logic              ova_w;
  logic              ovb_w;
  logic [32:0]       head;

`ifdef ADC_FRAME_DECIM_EN
  localparam int ACC_W = BIT_WIDTH + DECIM_LOG2;

  logic [DECIM_LOG2-1:0] grp;
  logic [ACC_W-1:0]      acc_a;
  logic [ACC_W-1:0]      acc_b;
  logic [ACC_W-1:0]      sum_a;
  logic [ACC_W-1:0]      sum_b;
  logic                  or_a;
  logic                  or_b;
  logic                  grp_end;

  assign sum_a    = acc_a + ACC_W'(data_a_in);
  assign sum_b    = acc_b + ACC_W'(data_b_in);
  assign grp_end  = &grp;
  assign word_vld = (state == CAPTURE) && sample_valid_in && grp_end;
  assign a_w      = DATA_W'(sum_a >> DECIM_LOG2);
  assign b_w      = DATA_W'(sum_b >> DECIM_LOG2);
  assign ova_w    = or_a | overrange_a_in;
  assign ovb_w    = or_b | overrange_b_in;

  // Holding the group clear while armed aligns it to the trigger.
  always_ff @(posedge clk_in) begin
    if (rst_in || state == ARMED) begin
      grp   <= '0;
      acc_a <= '0;
      acc_b <= '0;
      or_a  <= 1'b0;
      or_b  <= 1'b0;
    end else if (state == CAPTURE && sample_valid_in) begin
      grp <= grp + 1'b1;
      if (grp_end) begin
        acc_a <= '0;
        acc_b <= '0;
        or_a  <= 1'b0;
        or_b  <= 1'b0;
      end else begin
        acc_a <= sum_a;
        acc_b <= sum_b;
        or_a  <= ova_w;
        or_b  <= ovb_w;
      end
    end
  end
`else
  assign word_vld = (state == CAPTURE) && sample_valid_in;
  assign a_w      = DATA_W'(data_a_in);
  assign b_w      = DATA_W'(data_b_in);
  assign ova_w    = overrange_a_in;
  assign ovb_w    = overrange_b_in;
`endif

  // The last word may use the slot reserved for it.
  assign is_last = (word_cnt == CNT_W'(FRAME_LEN - 1));
  assign room    = is_last ? !full
                           : (occ < OCC_W'(FIFO_DEPTH - 1));
  assign push    = word_vld && room;

  adc_frame_fifo #(
    .WIDTH (33),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .push  (push),
    .din   ({is_last, pack_word(a_w, b_w, ova_w, ovb_w)}),
    .pop   (m_ready_in),
    .dout  (head),
    .count (occ),
    .full  (full),
    .empty (empty)
  );

  assign m_valid_out = !empty;
  assign m_data_out  = head[31:0];
  assign m_last_out  = head[32];
  assign busy_out    = (state == CAPTURE) || (state == DRAIN);

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (enable_in) state_nx = ARMED;
      ARMED:   if (!enable_in)     state_nx = IDLE;
               else if (trigger_in) state_nx = CAPTURE;
      CAPTURE: if (word_vld && is_last) state_nx = DRAIN;
      DRAIN:   if (empty) state_nx = enable_in ? ARMED : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      word_cnt        <= '0;
      overflow_out    <= 1'b0;
      frame_count_out <= '0;
    end else begin
      if (state == ARMED) word_cnt <= '0;
      else if (word_vld)  word_cnt <= word_cnt + 1'b1;
      if (word_vld && !room) overflow_out <= 1'b1;
      if (m_valid_out && m_ready_in && m_last_out)
        frame_count_out <= frame_count_out + 1'b1;
    end
  end

endmodule
